// File: rtl/alu_seq.sv
// Sequential front-end for a 32-bit MIPS-style ALU: latches an instruction, drives the ALU, captures the result.
// Define ALU_SEQ_BEQ_EN to decode beq (opcode 000100) as SUB; otherwise it is illegal.
module alu_seq #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_sel,
    input  logic [31:0] alu_dout,
    output logic        busy,
    output logic        ack,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {B_RT, B_SEXT, B_ZEXT} bsrc_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] sel;
        bsrc_t      bsrc;
    } dec_t;

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_SLT = 3'b111;
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t d;
        d.legal = 1'b1;
        d.sel   = SEL_ADD;
        d.bsrc  = B_RT;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: d.sel = SEL_ADD;
                    6'b100010: d.sel = SEL_SUB;
                    6'b100100: d.sel = SEL_AND;
                    6'b100101: d.sel = SEL_OR;
                    6'b101010: d.sel = SEL_SLT;
                    default:   d.legal = 1'b0;
                endcase
            end
            6'b001000: d.bsrc = B_SEXT;
            6'b001010: begin d.sel = SEL_SLT; d.bsrc = B_SEXT; end
            6'b100011: d.bsrc = B_SEXT;
            6'b101011: d.bsrc = B_SEXT;
            6'b001100: begin d.sel = SEL_AND; d.bsrc = B_ZEXT; end
            6'b001101: begin d.sel = SEL_OR;  d.bsrc = B_ZEXT; end
`ifdef ALU_SEQ_BEQ_EN
            6'b000100: d.sel = SEL_SUB;
`endif
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  opcode_q, opcode_d, funct_q, funct_d;
    logic [31:0] rs_q, rs_d, rt_q, rt_d;
    logic [15:0] imm_q, imm_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d, illegal_q, illegal_d;
    dec_t        dec;

    // One decoder: live fields judge legality in IDLE, latched fields drive the ALU in EXEC.
    always_comb begin
        if (state_q == IDLE) dec = decode(opcode, funct);
        else                 dec = decode(opcode_q, funct_q);
    end

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = SEL_ADD;
        if (state_q == EXEC) begin
            alu_a   = rs_q;
            alu_sel = dec.sel;
            case (dec.bsrc)
                B_SEXT:  alu_b = {{16{imm_q[15]}}, imm_q};
                B_ZEXT:  alu_b = {16'h0000, imm_q};
                default: alu_b = rt_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        imm_d     = imm_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    opcode_d = opcode;
                    funct_d  = funct;
                    rs_d     = rs_val;
                    rt_d     = rt_val;
                    imm_d    = imm;
                    if (dec.legal) begin
                        state_d = EXEC;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d   = DONE;
                        result_d  = '0;
                        zero_d    = 1'b1;
                        illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d   = DONE;
                    result_d  = alu_dout;
                    zero_d    = (alu_dout == '0);
                    illegal_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opcode_q  <= '0;
            funct_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            imm_q     <= imm_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign ack     = (state_q == DONE);
    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, cycles operands are held on the ALU port before the result is captured; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  1  request; level, sampled only in IDLE.
REQ-005 opcode  input  6  instruction opcode field.
REQ-006 funct  input  6  instruction funct field (R-type).
REQ-007 rs_val  input  32  first source operand.
REQ-008 rt_val  input  32  second source operand (R-type and BEQ).
REQ-009 imm  input  16  immediate field (I-type).
REQ-010 alu_a, alu_b  output  32 each  operands driven to the 32-bit ALU.
REQ-011 alu_sel  output  3  ALU control code: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
REQ-012 alu_dout  input  32  combinational result returned by the ALU.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 ack  output  1  one-cycle completion pulse.
REQ-015 result  output  32  captured result; held until the next capture or reset.
REQ-016 zero  output  1  registered (result == 0), updated together with result.
REQ-017 illegal  output  1  registered flag: last accepted request did not decode.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-019 Transitions SHALL be: IDLE&req&legal->EXEC; IDLE&req&illegal->DONE; EXEC&cnt==0->DONE; DONE->IDLE, unconditionally.
REQ-020 On acceptance, opcode, funct, rs_val, rt_val and imm SHALL be sampled once into registers; later input changes SHALL be ignored until the next acceptance.
REQ-021 On entry to EXEC, cnt SHALL load EXEC_CYCLES-1 and decrement each EXEC cycle.
REQ-022 At the EXEC edge with cnt==0, result SHALL load alu_dout, zero SHALL load (alu_dout==0) and illegal SHALL clear.
REQ-023 ack SHALL be 1 exactly in DONE; with EXEC_CYCLES=N, ack SHALL assert N+1 cycles after the acceptance edge.
REQ-024 Decode SHALL be: opcode 000000 with funct 100000/100010/100100/100101/101010 -> ADD/SUB/AND/OR/SLT, with alu_b=rt.
REQ-025 Decode SHALL be: addi 001000 -> ADD, slti 001010 -> SLT, lw 100011 -> ADD and sw 101011 -> ADD, each with alu_b = sign-extended imm.
REQ-026 Decode SHALL be: andi 001100 -> AND and ori 001101 -> OR, each with alu_b = zero-extended imm.
REQ-027 alu_a SHALL be the registered rs in every legal operation.
REQ-028 Any other opcode/funct SHALL be illegal: at acceptance, go to DONE and set result=0, zero=1, illegal=1.
REQ-029 Outside EXEC, alu_a=0, alu_b=0 and alu_sel=010.
REQ-030 req in EXEC or DONE SHALL be ignored; a req still high in IDLE after DONE SHALL be accepted, giving back-to-back service every N+2 cycles.

Reset
REQ-031 While reset=1 at a clk edge, the state SHALL go to IDLE and result=0, zero=0, illegal=0, ack=0, busy=0 and cnt=0.
REQ-032 req SHALL be ignored in any cycle where reset=1.
REQ-033 Reset during EXEC or DONE SHALL abort the operation with no capture and no ack.

Configuration
REQ-034 Macro ALU_SEQ_BEQ_EN defined: opcode 000100 (beq) SHALL decode as SUB with alu_b=rt, so zero=1 means rs==rt.
REQ-035 Macro ALU_SEQ_BEQ_EN undefined: opcode 000100 SHALL be illegal per REQ-028.

Verification
REQ-036 EXEC_CYCLES=1: R-type ADD with rs=5, rt=7 -> ack 2 cycles after acceptance, result=12, zero=0, alu_sel observed=010.
REQ-037 slti with rs=0xFFFFFFFE (-2), imm=0x0003 -> alu_b=3, alu_sel=111, result=1; then andi with rs=0xFFFF1234, imm=0x8001 -> alu_b=0x00008001, result=0x00000000, zero=1.
REQ-038 opcode 111111 -> ack 1 cycle after acceptance, illegal=1, result=0, busy high for exactly 1 cycle.
REQ-039 EXEC_CYCLES=4, SUB with rs=9, rt=9, reset pulsed on the 2nd EXEC cycle -> no ack, result=0, busy=0 the cycle after reset.
REQ-040 req held high over 3 ADD requests with EXEC_CYCLES=1 -> ack every 3 cycles; the fields change during EXEC and the result uses only the accepted values.
REQ-041 beq with rs=rt=0x1234: with ALU_SEQ_BEQ_EN -> alu_sel=110, result=0, zero=1; without ALU_SEQ_BEQ_EN -> illegal=1.
